mips32_fetch_queue: RTL

- Parametrised instruction-fetch front end for the next-generation mips32 pipeline. Replaces the single IF_ID latch with a DEPTH-entry prefetch queue.
- Issues word fetches to a 1-cycle-latency instruction memory and hands {IR, NPC} to decode over a valid/ready handshake.
- Supports redirect (taken branch) flush and HLT-opcode stop.
- Sits between instruction memory and the ID stage.

---
 rtl/mips32_pkg.sv | 30 +++
 rtl/mips32_fetch_fifo.sv | 60 ++++++
 rtl/mips32_fetch_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips32_pkg.sv
// mips32_pkg
//   Shared definitions for the mips32 pipeline front end: opcode encodings,
//   opcode field position inside the instruction word and default widths.
//   No ports (package).
package mips32_pkg;

  localparam int DEF_PC_W = 32;
  localparam int DEF_IR_W = 32;

  // Opcode field occupies the top six bits of the instruction word.
  localparam int OPC_W   = 6;
  localparam int OPC_MSB = DEF_IR_W - 1;
  localparam int OPC_LSB = DEF_IR_W - OPC_W;

  localparam logic [OPC_W-1:0] OPC_ADD   = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_SUB   = 6'b000001;
  localparam logic [OPC_W-1:0] OPC_AND   = 6'b000010;
  localparam logic [OPC_W-1:0] OPC_OR    = 6'b000011;
  localparam logic [OPC_W-1:0] OPC_SLT   = 6'b000100;
  localparam logic [OPC_W-1:0] OPC_MUL   = 6'b000101;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b001001;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001010;
  localparam logic [OPC_W-1:0] OPC_SUBI  = 6'b001011;
  localparam logic [OPC_W-1:0] OPC_SLTI  = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_BNEQZ = 6'b001101;
  localparam logic [OPC_W-1:0] OPC_BEQZ  = 6'b001110;
  localparam logic [OPC_W-1:0] OPC_HLT   = 6'b111111;

endpackage

// File: rtl/mips32_fetch_fifo.sv
// mips32_fetch_fifo
//   Generic DEPTH x WIDTH circular buffer used as the fetch prefetch queue.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push, wdata   write one entry at the tail (caller guarantees not full)
//     pop           remove the head entry (caller guarantees not empty)
//     flush         discard all entries; overrides push and pop
//     rdata         head entry (undefined while empty)
//     count         number of stored entries, 0..DEPTH
module mips32_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Storage needs no reset; count decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue
//   Instruction-fetch front end: issues word fetches to a 1-cycle-latency
//   instruction memory, buffers {IR, NPC} in a DEPTH-entry queue and hands
//   the head to decode over a valid/ready handshake. Handles redirect flush
//   and stops fetching once an HLT opcode has been enqueued.
//   Build option: define FETCHQ_BYPASS_EN to present a response arriving at
//   an empty queue on id_ir/id_npc in the same cycle.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     imem_req, imem_addr          fetch request / word address
//     imem_rdata                   instruction, valid the cycle after imem_req
//     id_valid, id_ready           head handshake towards decode
//     id_ir, id_npc                head instruction and its fetch PC + 1
//     redirect_valid, redirect_pc  taken branch / jump target
//     halted                       HLT fetched, fetch stopped
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int               PC_W     = DEF_PC_W,
  parameter int               IR_W     = DEF_IR_W,
  parameter int               ADDR_W   = 10,
  parameter int               DEPTH    = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [OPC_W-1:0] HLT_OPC  = OPC_HLT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [IR_W-1:0]   imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [IR_W-1:0]   id_ir,
  output logic [PC_W-1:0]   id_npc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = IR_W + PC_W;

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  issued_pc;
  logic             inflight;
  logic             drop;
  logic [IR_W-1:0]  hold_ir;
  logic [PC_W-1:0]  hold_npc;

  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             resp_valid;
  logic             resp_hlt;
  logic [PC_W-1:0]  resp_npc;
  logic             byp;
  logic             deq;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CNT_W:0]   credit;
  logic             issue;

  // A redirect discards the response arriving in its own cycle as well.
  assign resp_valid = inflight && !drop && !redirect_valid;
  assign resp_npc   = issued_pc + PC_W'(1);
  assign resp_hlt   = resp_valid && (imem_rdata[IR_W-1 -: OPC_W] == HLT_OPC);

`ifdef FETCHQ_BYPASS_EN
  assign byp = (count == '0) && resp_valid;
`else
  assign byp = 1'b0;
`endif

  assign id_valid  = (count != '0) || byp;
  assign deq       = id_valid && id_ready;
  assign fifo_pop  = deq && (count != '0);
  assign fifo_push = resp_valid && !(byp && id_ready);

  // Outstanding fetches are counted so a response always finds a free slot.
  assign credit    = ({1'b0, count} + (CNT_W+1)'(inflight)) - (CNT_W+1)'(deq);
  assign issue     = !rst && !halted && !redirect_valid && (credit < (CNT_W+1)'(DEPTH));
  assign imem_req  = issue;
  assign imem_addr = pc[ADDR_W-1:0];

  // When nothing is valid the outputs keep whatever was last presented.
  always_comb begin
    id_ir  = hold_ir;
    id_npc = hold_npc;
    if (count != '0) begin
      id_ir  = head[ENT_W-1 -: IR_W];
      id_npc = head[PC_W-1:0];
    end else if (byp) begin
      id_ir  = imem_rdata;
      id_npc = resp_npc;
    end
  end

  mips32_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .wdata ({imem_rdata, resp_npc}),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
      drop      <= 1'b0;
      halted    <= 1'b0;
      hold_ir   <= '0;
      hold_npc  <= '0;
    end else begin
      inflight <= issue;
      // The fetch issued alongside an HLT enqueue must never be delivered.
      drop     <= redirect_valid || resp_hlt;
      hold_ir  <= id_ir;
      hold_npc <= id_npc;
      if (issue) issued_pc <= pc;
      if (redirect_valid) begin
        pc     <= redirect_pc;
        halted <= 1'b0;
      end else begin
        if (issue)    pc     <= pc + PC_W'(1);
        if (resp_hlt) halted <= 1'b1;
      end
    end
  end

endmodule
